// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART receiver and transmitter.
//   - DEFAULT_CLOCKS_PER_BIT : default serial bit period in clock cycles
//   - uart_state_e           : receiver/transmitter frame state encoding
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DEFAULT_CLOCKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_e;

endpackage

// File: rtl/bit_synchronizer.sv
// -----------------------------------------------------------------------------
// bit_synchronizer
//   Two-flop synchronizer that brings an asynchronous single-bit signal into
//   the clk_i domain. Both flops reset to RESET_VALUE.
//   Ports:
//     clk_i  : destination clock
//     rst_i  : asynchronous active-high reset
//     d_i    : asynchronous input
//     q_o    : synchronized output (two clk_i cycles of latency)
// -----------------------------------------------------------------------------
module bit_synchronizer #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/receiver.sv
// -----------------------------------------------------------------------------
// receiver
//   UART receiver, 8N1, LSB first, idle-high line. Bits are sampled at the
//   centre of each bit period, measured from the synchronized start-bit edge.
//   Ports:
//     clock             : single clock, all state updates on its rising edge
//     reset             : asynchronous active-high reset
//     serial_connection : asynchronous serial input line
//     data              : last correctly framed byte
//     valid             : one-cycle pulse, new byte on data
//     framing_error     : one-cycle pulse, stop bit sampled low
//     busy              : high whenever the receiver is not IDLE
// -----------------------------------------------------------------------------
module receiver
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_connection,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);

  logic        rx_s;
  uart_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        ferr_q;
  logic        rx_prev_q;
  logic [1:0]  settle_q;

  bit_synchronizer #(
    .RESET_VALUE (1'b1)
  ) u_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (serial_connection),
    .q_o   (rx_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      rx_prev_q <= 1'b0;
      settle_q  <= '0;
    end else begin
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      settle_q <= {settle_q[0], 1'b1};
      // The synchronizer's reset value is not a real line level, so the
      // edge detector only remembers a high that was actually observed.
      // This keeps a line that is already low at reset release from
      // looking like a fresh start bit.
      rx_prev_q <= rx_s & settle_q[1];
      cnt_q     <= (cnt_q == BIT_LAST) ? '0 : cnt_q + CW'(1);

      case (state_q)
        IDLE: begin
          if (!rx_s && rx_prev_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          // Mid start bit: still low means a real frame, high is a glitch.
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= IDLE;
            end else begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            shift_q[bit_idx_q] <= rx_s;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        STOP: begin
          // Leaving at the stop-bit centre lets IDLE catch a start edge
          // anywhere in the second half of the stop bit.
          if (cnt_q == BIT_LAST) begin
            if (rx_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data          = data_q;
  assign valid         = valid_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_receiver.sv
// -----------------------------------------------------------------------------
// tb_receiver
//   Scoreboard bench for the UART receiver at CLOCKS_PER_BIT = 16. The driver
//   serialises frames and pushes the expected pulse (kind, cycle, data) into a
//   queue; an independent monitor pops and compares on every valid or
//   framing_error pulse.
// -----------------------------------------------------------------------------
module tb_receiver;

  localparam int CPB = 16;
  // Pin-to-pulse latency: 2 synchronizer cycles + 9.5 bit periods + 1.
  localparam int LAT = 2 + (19 * CPB) / 2 + 1;

  logic       clock;
  logic       reset;
  logic       serial_connection;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;
  logic       busy;

  receiver #(
    .CLOCKS_PER_BIT (CPB)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .serial_connection (serial_connection),
    .data              (data),
    .valid             (valid),
    .framing_error     (framing_error),
    .busy              (busy)
  );

  typedef struct {
    int         cyc;
    bit         is_valid;
    logic [7:0] d;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] last_good = 8'h00;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Hold the line at v for n cycles; starts and ends 1 time unit after a posedge.
  task automatic hold(input logic v, input int n);
    serial_connection = v;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Park on the falling edge where the cycle counter reads t.
  task automatic at_neg(input int t);
    do @(negedge clock); while (cyc < t);
  endtask

  task automatic realign();
    @(posedge clock);
    #1;
  endtask

  // Serialise one 8N1 frame and record the pulse it must produce.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    exp_t e;
    e.cyc      = cyc + LAT;
    e.is_valid = stop_ok;
    e.d        = stop_ok ? b : last_good;
    if (stop_ok) last_good = b;
    sb.push_back(e);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop_ok, CPB);
  endtask

  // Monitor: compares every output pulse against the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      if (valid && framing_error) begin
        n_checks++;
        n_fail++;
        $display("FAIL pulse_exclusive: valid and framing_error both high (cycle %0d)", cyc);
      end
      if (valid || framing_error) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: valid=%0b framing_error=%0b data=0x%0h, expected no pulse (cycle %0d)",
                   valid, framing_error, data, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pulse_kind", {30'd0, valid, framing_error}, e.is_valid ? 32'd2 : 32'd1);
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_data", {24'd0, data}, {24'd0, e.d});
        end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missed_pulse: no pulse seen, expected %s at cycle %0d (now %0d)",
                 sb[0].is_valid ? "valid" : "framing_error", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    serial_connection = 1'b1;
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("reset_data", {24'd0, data}, 32'h00);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_ferr", {31'd0, framing_error}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    hold(1'b1, 2 * CPB);

    // Basic frame.
    send_frame(8'h55, 1'b1);
    hold(1'b1, 2 * CPB);
    check("data_0x55", {24'd0, data}, 32'h55);

    // Short low glitch: START rejects it within half a bit.
    n = cyc;
    hold(1'b0, 4);
    serial_connection = 1'b1;
    at_neg(n + 5);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    at_neg(n + 11);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    realign();
    hold(1'b1, 2 * CPB);

    // Bad stop bit, then a good frame after the line returns high.
    send_frame(8'hA3, 1'b0);
    hold(1'b1, 2 * CPB);
    check("data_kept_after_ferr", {24'd0, data}, 32'h55);
    send_frame(8'h3C, 1'b1);
    hold(1'b1, 2 * CPB);

    // Back-to-back frames, no idle between them.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    hold(1'b1, 2 * CPB);
    check("data_0xFF", {24'd0, data}, 32'hFF);

    // Break: 40 bit periods low gives a single framing error.
    begin
      exp_t e;
      e.cyc = cyc + LAT;
      e.is_valid = 1'b0;
      e.d = last_good;
      sb.push_back(e);
    end
    hold(1'b0, 40 * CPB);
    check("break_busy_held", {31'd0, busy}, 32'd1);
    n = cyc;
    serial_connection = 1'b1;
    at_neg(n + 2);
    check("break_busy_before_idle", {31'd0, busy}, 32'd1);
    at_neg(n + 3);
    check("break_busy_released", {31'd0, busy}, 32'd0);
    realign();
    hold(1'b1, 2 * CPB);

    // Reset in the middle of bit 3 of 0x81; the line is low at release.
    hold(1'b0, CPB);          // start
    hold(1'b1, CPB);          // bit0
    hold(1'b0, 2 * CPB);      // bit1, bit2
    hold(1'b0, CPB / 2);      // first half of bit3
    reset = 1'b1;
    sb.delete();
    last_good = 8'h00;
    hold(1'b0, 2);
    check("midreset_data", {24'd0, data}, 32'h00);
    check("midreset_valid", {31'd0, valid}, 32'd0);
    check("midreset_ferr", {31'd0, framing_error}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    hold(1'b0, CPB / 2 - 2 + 20);
    check("no_false_start_busy", {31'd0, busy}, 32'd0);
    hold(1'b0, 3 * CPB - 20); // rest of bit4..bit6
    hold(1'b1, CPB);          // bit7
    hold(1'b1, 3 * CPB);      // stop + idle
    check("post_reset_data", {24'd0, data}, 32'h00);
    send_frame(8'h81, 1'b1);
    hold(1'b1, 2 * CPB);
    check("data_0x81", {24'd0, data}, 32'h81);

    // Randomised traffic.
    for (int k = 0; k < 30; k++) begin
      logic [7:0] b;
      bit ok;
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 9) != 0);
      send_frame(b, ok);
      if (ok) hold(1'b1, $urandom_range(0, 2 * CPB));
      else    hold(1'b1, CPB + $urandom_range(0, CPB));
    end
    hold(1'b1, 200);
    check("scoreboard_drained", sb.size(), 32'd0);
    check("final_data", {24'd0, data}, {24'd0, last_good});
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
